// File: rtl/regfl_pkg.sv
// Shared definitions for the 8x64 register file: geometry, read-port state
// encoding and the register slice layout on the flattened contents bus.
package regfl_pkg;

  localparam int REG_W  = 64;
  localparam int REG_N  = 8;
  localparam int REG_AW = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Register 0 occupies the most significant slice of the flattened bus.
  function automatic int reg_lsb(input int i, input int w, input int n);
    return (n * w) - w - (w * i);
  endfunction

endpackage

// File: rtl/regfl_mux.sv
// Combinational N:1 word select from the flattened register-file bus.
import regfl_pkg::*;

module regfl_mux #(
  parameter int W  = REG_W,
  parameter int N  = REG_N,
  parameter int AW = REG_AW
) (
  input  logic [N*W-1:0] q_in,
  input  logic [AW-1:0]  idx,
  output logic [W-1:0]   word
);

  logic [W-1:0] words [N];

  for (genvar g = 0; g < N; g++) begin : g_slice
    assign words[g] = q_in[reg_lsb(g, W, N) +: W];
  end

  assign word = words[idx];

endmodule

// File: rtl/regfl_rd.sv
// Burst read port: streams a wrapping run of registers, one snapshotted word
// per beat, over a valid/ready channel.
import regfl_pkg::*;

module regfl_rd #(
  parameter int W  = REG_W,
  parameter int N  = REG_N,
  parameter int AW = REG_AW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] q_in,
  input  logic           req,
  output logic           req_rdy,
  input  logic [AW-1:0]  addr,
  input  logic [AW-1:0]  len,
  output logic [W-1:0]   dout,
  output logic           dvalid,
  input  logic           dready,
  output logic           dlast,
  output logic           busy
);

  state_t        state, state_nx;
  logic [AW-1:0] idx, idx_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic [W-1:0]  dout_nx;
  logic          dvalid_nx;
  logic          dlast_nx;
  logic [AW-1:0] sel;
  logic [AW-1:0] idx_inc;
  logic [W-1:0]  word;

  assign idx_inc = idx + AW'(1);

  // The single mux serves both the first word (addr) and every following beat (idx+1).
  regfl_mux #(
    .W  (W),
    .N  (N),
    .AW (AW)
  ) u_mux (
    .q_in (q_in),
    .idx  (sel),
    .word (word)
  );

  // Next-state, mux select and next output values.
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    cnt_nx    = cnt;
    dout_nx   = dout;
    dvalid_nx = dvalid;
    dlast_nx  = dlast;
    sel       = addr;
    case (state)
      IDLE: begin
        sel = addr;
        if (req) begin
          idx_nx    = addr;
          cnt_nx    = len;
          dout_nx   = word;
          dlast_nx  = (len == {AW{1'b0}});
          dvalid_nx = 1'b1;
          state_nx  = SEND;
        end else begin
          dvalid_nx = 1'b0;
          dlast_nx  = 1'b0;
          state_nx  = IDLE;
        end
      end
      SEND: begin
        sel = idx_inc;
        if (dready) begin
          if (cnt != {AW{1'b0}}) begin
            idx_nx    = idx_inc;
            cnt_nx    = cnt - AW'(1);
            dout_nx   = word;
            dlast_nx  = (cnt == AW'(1));
            dvalid_nx = 1'b1;
            state_nx  = SEND;
          end else begin
            // Last beat taken: dout keeps its final word.
            dvalid_nx = 1'b0;
            dlast_nx  = 1'b0;
            state_nx  = IDLE;
          end
        end else begin
          state_nx = SEND;
        end
      end
      default: begin
        dvalid_nx = 1'b0;
        dlast_nx  = 1'b0;
        state_nx  = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any burst immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= {AW{1'b0}};
      cnt    <= {AW{1'b0}};
      dout   <= {W{1'b0}};
      dvalid <= 1'b0;
      dlast  <= 1'b0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      cnt    <= cnt_nx;
      dout   <= dout_nx;
      dvalid <= dvalid_nx;
      dlast  <= dlast_nx;
    end
  end

  assign req_rdy = (state == IDLE);
  assign busy    = (state == SEND);

endmodule

// File: doc/regfl_rd.md
Name: regfl_rd

Overview:
- Burst read port for the 8x64 register file, which exposes all registers on a flattened 512-bit bus and has no read path of its own.
- Accepts a start index and a burst length on a request handshake.
- Streams the selected registers one 64-bit word per beat over a valid/ready output channel, wrapping from register 7 to register 0.
- Sits between the register file and any consumer that needs word-serial access.

Parameters:
- W, 64, register width in bits.
- N, 8, number of registers; must be a power of two.
- AW, 3, index width; equals log2(N).

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- q_in  input  N*W  flattened register-file contents. Register i sits at bits [N*W-1-W*i : N*W-W-W*i], so register 0 is the MSB slice.
- req  input  1  read request.
- req_rdy  output  1  request may be accepted; high only in IDLE.
- addr  input  AW  start register index; sampled on request accept.
- len  input  AW  burst length minus one (0 gives 1 word, 7 gives 8 words); sampled on accept.
- dout  output  W  current data word.
- dvalid  output  1  dout is valid.
- dready  input  1  consumer accepts the beat.
- dlast  output  1  current beat is the final one of the burst.
- busy  output  1  burst in progress; equals the inverse of req_rdy.

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE; req_rdy=1, dvalid=0, dlast=0, busy=0.
  - dout=0; internal index and count registers = 0.
- States: IDLE, SEND.
- IDLE:
  - req_rdy=1.
  - On req=1 at a clock edge: latch idx=addr and cnt=len, load dout with register addr from q_in, set dlast=(len==0), dvalid=1, go to SEND.
  - Latency: dvalid rises on the first edge after the request edge, i.e. 1 cycle.
- SEND, beat held (dvalid=1, dready=0):
  - dout, dlast and dvalid hold stable even if q_in changes.
  - Data is snapshotted at load time, never live.
- SEND, beat accepted (dvalid=1, dready=1, cnt!=0):
  - idx = idx+1 modulo N (7 wraps to 0); cnt = cnt-1.
  - dout reloads from q_in at the new idx; dlast = (new cnt==0); dvalid stays 1.
  - Result: one beat per cycle with no bubble under continuous dready.
- SEND, beat accepted with cnt==0:
  - dvalid=0, dlast=0, go to IDLE; dout holds its last value.
  - req_rdy=1 on the next cycle, so there is exactly one bubble between bursts.
- req while busy: ignored, not queued; req_rdy=0 signals this.
- Simultaneous register-file write and load: dout takes the q_in value present before the edge. There is no write-through forwarding.
- Arithmetic: idx and cnt are AW bits wide with natural modulo wrap.
  - Burst length is 1..N, so no word is ever repeated within a burst.
- Reset asserted mid-burst: immediate abort; outputs take reset values asynchronously; no partial-beat completion after release.
- Full-length burst (len=N-1) starting at any addr visits every register exactly once, in ascending order with wrap.

Decomposition:
- Shared package regfl_pkg:
  - constants REG_W=64, REG_N=8, REG_AW=3;
  - state encoding IDLE=1'b0, SEND=1'b1;
  - the slice formula for register i as a constant function, shared with the write side.
- Sub-module regfl_mux: purely combinational N:1 word select (q_in, idx) -> W-bit word.
  - Instantiated once; all sequential logic stays in regfl_rd.

Test Plan:
- Reset then idle, with rst pulsed high mid-cycle: req_rdy=1, dvalid=0, dout=0 asynchronously; no change while req=0.
- Single read, q_in reg 3 = 64'hDEADBEEF_00000003, addr=3, len=0, dready=1 -> one cycle later dout=DEADBEEF_00000003, dvalid=1, dlast=1; req_rdy=1 one cycle after the accept.
- Wrap burst, reg i = 64'h1111_1111_1111_1111*i, addr=6, len=3, dready=1 -> beats reg6, reg7, reg0, reg1 on consecutive cycles; dlast only on the reg1 beat.
- Backpressure: hold dready=0 for 3 cycles on beat 2 while q_in reg changes to 64'h0 -> dout keeps the snapshot value; the burst resumes with no lost or repeated beat.
- Request during busy: req=1 pulsed mid-burst with addr=0 -> ignored, and the current burst completes unchanged.
- Reset mid-burst after beat 2 of 8 -> dvalid=0 immediately; after release a new req with addr=5, len=7 returns reg5, 6, 7, 0, 1, 2, 3, 4.
